// File: rtl/serializer16_pkg.sv
// Shared widths, state encoding and index helpers for the 16-bit serializer.
package serializer16_pkg;

    localparam int W     = 16;
    localparam int IDX_W = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    function automatic logic [IDX_W-1:0] start_idx(input bit msb_first);
        return msb_first ? 4'd15 : 4'd0;
    endfunction

    function automatic logic [IDX_W-1:0] last_idx(input bit msb_first);
        return msb_first ? 4'd0 : 4'd15;
    endfunction

endpackage

// File: rtl/mux16x1.sv
// 16:1 bit-select multiplexer: z_o is the bit of d_i addressed by s_i.
module mux16x1 (
    input  logic [15:0] d_i,
    input  logic [3:0]  s_i,
    output logic        z_o
);

    assign z_o = d_i[s_i];

endmodule

// File: rtl/serializer16.sv
// Parallel-in, serial-out stage: latches a word on a valid/ready handshake and
// steps the mux16x1 select one bit per accepted serial beat.
//
//   state | meaning
//   IDLE  | no word held; in_ready high, out_valid low
//   SHIFT | word held; cnt addresses the bit currently offered on out_bit
module serializer16
    import serializer16_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_bit,
    output logic [IDX_W-1:0] sel,
    output logic             busy,
    output logic             done
);

    localparam logic [IDX_W-1:0] START = start_idx(MSB_FIRST);
    localparam logic [IDX_W-1:0] LAST  = last_idx(MSB_FIRST);

    state_e           state_q, state_d;
    logic [W-1:0]     data_q, data_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             last_beat;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            cnt_q   <= START;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // Last bit handed off this cycle; lets the next word load with no bubble.
    assign last_beat = (state_q == SHIFT) && (cnt_q == LAST) && out_ready;
    assign in_ready  = (state_q == IDLE) || last_beat;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_d  = in_data;
                    cnt_d   = START;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (out_ready) begin
                    if (cnt_q == LAST) begin
                        done_d = 1'b1;
                        cnt_d  = START;
                        if (in_valid) begin
                            data_d = in_data;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        cnt_d = MSB_FIRST ? (cnt_q - 4'd1) : (cnt_q + 4'd1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign out_valid = (state_q == SHIFT);
    assign busy      = (state_q == SHIFT);
    assign sel       = cnt_q;
    assign done      = done_q;

    mux16x1 u_mux (
        .d_i (data_q),
        .s_i (cnt_q),
        .z_o (out_bit)
    );

endmodule

// File: tb/tb_serializer16.sv
// Self-checking bench for serializer16: LSB-first and MSB-first instances share
// stimulus; expectations come from per-beat bit indexing of the accepted word.
module tb_serializer16;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [15:0] in_data;

    logic       in_ready0, out_valid0, out_bit0, busy0, done0;
    logic [3:0] sel0;
    logic       in_ready1, out_valid1, out_bit1, busy1, done1;
    logic [3:0] sel1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    serializer16 #(.MSB_FIRST(1'b0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .in_data(in_data), .out_valid(out_valid0), .out_ready(out_ready),
        .out_bit(out_bit0), .sel(sel0), .busy(busy0), .done(done0)
    );

    serializer16 #(.MSB_FIRST(1'b1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .in_data(in_data), .out_valid(out_valid1), .out_ready(out_ready),
        .out_bit(out_bit1), .sel(sel1), .busy(busy1), .done(done1)
    );

    task automatic load_word(input logic [15:0] w);
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = w;
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        @(negedge clk);
        #1;
        total++;
        if ({out_valid0, busy0, in_ready0, out_bit0, done0, sel0} !== {5'b00100, 4'd0}) begin
            bad++;
            $display("FAIL reset_lsb got=%b exp=%b", {out_valid0, busy0, in_ready0, out_bit0, done0, sel0}, {5'b00100, 4'd0});
        end
        total++;
        if ({out_valid1, busy1, in_ready1, out_bit1, done1, sel1} !== {5'b00100, 4'd15}) begin
            bad++;
            $display("FAIL reset_msb got=%b exp=%b", {out_valid1, busy1, in_ready1, out_bit1, done1, sel1}, {5'b00100, 4'd15});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single();
        logic [15:0] w = 16'hB53C;
        load_word(w);
        #1;
        total++;
        if (in_ready0 !== 1'b1) begin bad++; $display("FAIL single_load_ready got=%b exp=1", in_ready0); end
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            total++;
            if ({out_valid0, sel0, out_bit0, done0} !== {1'b1, 4'(i), w[i], 1'b0}) begin
                bad++;
                $display("FAIL single_beat i=%0d got=%b exp=%b", i, {out_valid0, sel0, out_bit0, done0}, {1'b1, 4'(i), w[i], 1'b0});
            end
            total++;
            if (in_ready0 !== (i == 15)) begin
                bad++;
                $display("FAIL single_in_ready i=%0d got=%b exp=%b", i, in_ready0, (i == 15));
            end
        end
        @(negedge clk);
        #1;
        total++;
        if ({done0, out_valid0, in_ready0} !== 3'b101) begin
            bad++;
            $display("FAIL single_done got=%b exp=101", {done0, out_valid0, in_ready0});
        end
        @(negedge clk);
        #1;
        total++;
        if (done0 !== 1'b0) begin bad++; $display("FAIL single_done_clear got=%b exp=0", done0); end
    endtask

    task automatic test_stall();
        logic [15:0] w = 16'hB53C;
        int idx = 0, stalls = 0, cycles = 0, dones = 0;
        load_word(w);
        for (int c = 0; c < 40 && idx < 16; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (idx == 5 && stalls < 3) begin
                out_ready = 1'b0;
                stalls++;
            end else begin
                out_ready = 1'b1;
            end
            #1;
            cycles++;
            dones += int'(done0);
            total++;
            if ({out_valid0, sel0, out_bit0} !== {1'b1, 4'(idx), w[idx]}) begin
                bad++;
                $display("FAIL stall_beat idx=%0d got=%b exp=%b", idx, {out_valid0, sel0, out_bit0}, {1'b1, 4'(idx), w[idx]});
            end
            if (out_ready) idx++;
        end
        out_ready = 1'b1;
        repeat (2) begin
            @(negedge clk);
            #1;
            dones += int'(done0);
        end
        total++;
        if (cycles !== 19) begin bad++; $display("FAIL stall_cycles got=%0d exp=19", cycles); end
        total++;
        if (dones !== 1) begin bad++; $display("FAIL stall_done_count got=%0d exp=1", dones); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] w;
        int idx;
        load_word(16'hB53C);
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            in_data  = 16'hFFFF;
            in_valid = (k < 16);
            out_ready = 1'b1;
            #1;
            w   = (k < 16) ? 16'hB53C : 16'hFFFF;
            idx = k % 16;
            total++;
            if ({out_valid0, sel0, out_bit0, in_ready0, done0} !== {1'b1, 4'(idx), w[idx], (idx == 15), (k == 16)}) begin
                bad++;
                $display("FAIL b2b_beat k=%0d got=%b exp=%b", k, {out_valid0, sel0, out_bit0, in_ready0, done0},
                         {1'b1, 4'(idx), w[idx], (idx == 15), (k == 16)});
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        total++;
        if ({done0, out_valid0} !== 2'b10) begin
            bad++;
            $display("FAIL b2b_second_done got=%b exp=10", {done0, out_valid0});
        end
    endtask

    task automatic test_msb_first();
        logic exp_bit;
        load_word(16'h8001);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            exp_bit = (i == 0) || (i == 15);
            total++;
            if ({out_valid1, sel1, out_bit1} !== {1'b1, 4'(15 - i), exp_bit}) begin
                bad++;
                $display("FAIL msb_beat i=%0d got=%b exp=%b", i, {out_valid1, sel1, out_bit1}, {1'b1, 4'(15 - i), exp_bit});
            end
        end
        @(negedge clk);
        #1;
        total++;
        if ({done1, out_valid1, in_ready1} !== 3'b101) begin
            bad++;
            $display("FAIL msb_done got=%b exp=101", {done1, out_valid1, in_ready1});
        end
    endtask

    task automatic test_async_reset();
        int dones = 0;
        load_word(16'hA5F0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        #1;
        total++;
        if (sel0 !== 4'd7) begin bad++; $display("FAIL areset_pre_sel got=%0d exp=7", sel0); end
        #2;
        rst = 1'b1;
        #1;
        total++;
        if ({out_valid0, busy0, in_ready0, done0, sel0} !== {4'b0010, 4'd0}) begin
            bad++;
            $display("FAIL areset_immediate got=%b exp=%b", {out_valid0, busy0, in_ready0, done0, sel0}, {4'b0010, 4'd0});
        end
        @(negedge clk);
        rst = 1'b0;
        load_word(16'h0001);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        total++;
        if ({out_valid0, sel0, out_bit0} !== {1'b1, 4'd0, 1'b1}) begin
            bad++;
            $display("FAIL areset_new_word got=%b exp=%b", {out_valid0, sel0, out_bit0}, {1'b1, 4'd0, 1'b1});
        end
        for (int i = 1; i < 16; i++) begin
            @(negedge clk);
            #1;
            dones += int'(done0);
        end
        total++;
        if (dones !== 0) begin bad++; $display("FAIL areset_spurious_done got=%0d exp=0", dones); end
        @(negedge clk);
        #1;
        total++;
        if (done0 !== 1'b1) begin bad++; $display("FAIL areset_word_done got=%b exp=1", done0); end
    endtask

    task automatic test_ignore_inputs();
        logic [15:0] w = 16'h6A93;
        load_word(w);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            in_data  = 16'($urandom);
            in_valid = (i < 15) ? i[0] : 1'b0;
            #1;
            total++;
            if ({in_ready0, sel0, out_bit0} !== {(i == 15), 4'(i), w[i]}) begin
                bad++;
                $display("FAIL ignore_beat i=%0d got=%b exp=%b", i, {in_ready0, sel0, out_bit0}, {(i == 15), 4'(i), w[i]});
            end
        end
        in_valid = 1'b0;
        @(negedge clk);
        #1;
        total++;
        if ({done0, out_valid0} !== 2'b10) begin bad++; $display("FAIL ignore_done got=%b exp=10", {done0, out_valid0}); end
    endtask

    task automatic test_random();
        logic        active = 1'b0, done_exp = 1'b0, done_next, exp_ready, pend = 1'b0;
        logic [15:0] word = '0, pend_word = '0;
        int          idx = 0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            if (!pend) begin
                pend      = ($urandom_range(0, 2) != 0);
                pend_word = 16'($urandom);
            end
            in_valid  = pend;
            in_data   = pend_word;
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            exp_ready = !active || (idx == 15 && out_ready);
            total++;
            if ({out_valid0, out_valid1, in_ready0, in_ready1, done0, done1} !==
                {active, active, exp_ready, exp_ready, done_exp, done_exp}) begin
                bad++;
                $display("FAIL rand_ctrl c=%0d got=%b exp=%b", c, {out_valid0, out_valid1, in_ready0, in_ready1, done0, done1},
                         {active, active, exp_ready, exp_ready, done_exp, done_exp});
            end
            if (active) begin
                total++;
                if ({sel0, out_bit0, sel1, out_bit1} !== {4'(idx), word[idx], 4'(15 - idx), word[15 - idx]}) begin
                    bad++;
                    $display("FAIL rand_data c=%0d got=%b exp=%b", c, {sel0, out_bit0, sel1, out_bit1},
                             {4'(idx), word[idx], 4'(15 - idx), word[15 - idx]});
                end
            end
            done_next = active && out_ready && (idx == 15);
            if (active && out_ready) begin
                if (idx == 15) active = 1'b0;
                else idx++;
            end
            if (in_valid && exp_ready) begin
                word   = pend_word;
                idx    = 0;
                active = 1'b1;
                pend   = 1'b0;
            end
            done_exp = done_next;
        end
        in_valid = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_stall();
        test_back_to_back();
        test_msb_first();
        test_async_reset();
        test_ignore_inputs();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serializer16.md
Name: serializer16

Overview:
- Parallel-in, serial-out stage that sits directly upstream of the 16:1 bit-select multiplexer (mux16x1) and drives its select input.
- Latches a 16-bit word through a valid/ready handshake, then steps a 4-bit select counter so that one bit per accepted beat appears on a serial valid/ready output.
- Used wherever a bus word must be shipped over a single wire.

Parameters:
- MSB_FIRST, 0, 0 = bit 0 sent first (select counts 0 up to 15); 1 = bit 15 sent first (select counts 15 down to 0).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream word present.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  16  parallel word; sampled only on an in_valid && in_ready edge.
- out_valid  output  1  out_bit is valid.
- out_ready  input  1  downstream accepts out_bit this cycle.
- out_bit  output  1  current serial bit.
- sel  output  4  current bit index (debug/observability).
- busy  output  1  high while in SHIFT.
- done  output  1  one-cycle pulse after the last bit of a word is accepted.

Behaviour:
- Reset (async, immediate): state=IDLE, data_reg=0, cnt=START, done=0. Outputs: out_valid=0, busy=0, in_ready=1, out_bit=0, sel=START. START = 0 if MSB_FIRST=0, else 15. LAST = 15 if MSB_FIRST=0, else 0.
- States: IDLE, SHIFT. Registers: data_reg[15:0], cnt[3:0], done.
- Combinational outputs:
  - out_valid = busy = (state==SHIFT).
  - sel = cnt.
  - out_bit = data_reg[cnt], produced by a mux16x1 instance (D=data_reg, S=cnt, Z=out_bit).
  - in_ready = (state==IDLE) || (state==SHIFT && cnt==LAST && out_ready).
  - out_valid never depends on out_ready.
- Load: on an edge with in_valid && in_ready: data_reg<=in_data, cnt<=START, state<=SHIFT. The first bit is valid in the cycle after the load edge.
- SHIFT, out_ready=0: hold all state; out_bit and sel remain stable.
- SHIFT, out_ready=1, cnt!=LAST: cnt<=cnt+1 (MSB_FIRST=0) or cnt-1 (MSB_FIRST=1).
- SHIFT, out_ready=1, cnt==LAST:
  - done<=1 on the following cycle.
  - If in_valid: load the new word and stay in SHIFT. There is no bubble between words.
  - Else: state<=IDLE, cnt<=START.
- done: register set only on the last-bit handshake; otherwise cleared to 0 each cycle. Exactly one pulse per word.
- Throughput: with out_ready held at 1, a word takes 16 cycles, and back-to-back words stream continuously.
- in_data changes or in_valid pulses while in_ready=0 are ignored. Upstream must hold in_valid until in_ready.
- The counter never wraps on its own; LAST always terminates the word.
- Reset mid-word discards the partial word. No done pulse is issued for it.

Decomposition:
- Shared package constants: W=16, IDX_W=4, and the state encoding (IDLE=1'b0, SHIFT=1'b1).
- One sub-module, the existing mux16x1, performs bit selection. The FSM and counter stay in serializer16.

Test Plan:
1. Reset, MSB_FIRST=0, load 16'hB53C, out_ready=1.
   - out_bit sequence is 0,0,1,1, 1,1,0,0, 1,0,1,0, 1,1,0,1, with sel running 0..15.
   - done pulses once, one cycle after the sel=15 beat.
   - Then in_ready=1 and out_valid=0.
2. Same word, drop out_ready for 3 cycles while sel=5.
   - sel=5 and out_bit=1 hold for those cycles.
   - The word completes in 19 cycles.
   - Exactly one done pulse.
3. Back-to-back words: 16'hB53C, then 16'hFFFF with in_valid held high.
   - in_ready rises only during the sel=15 && out_ready cycle.
   - The second word's bit 0 (1) follows with no gap.
   - Two done pulses, 16 cycles apart.
4. MSB_FIRST=1, load 16'h8001.
   - out_bit sequence is 1, fourteen 0s, 1, with sel running 15 down to 0.
5. Reset asserted mid-cycle at sel=7.
   - out_valid=0, busy=0, in_ready=1 and done=0 immediately, without waiting for a clock edge.
   - A new word 16'h0001 then starts at bit 0 (out_bit=1).
6. During SHIFT, toggle in_data and pulse in_valid before the last bit.
   - in_ready stays 0.
   - The serial output still matches the originally latched word.
